// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 instruction, ALU, condition and status encodings.
package y86_pkg;
    typedef enum logic [3:0] {
        I_HALT, I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
        I_OPQ, I_JXX, I_CALL, I_RET, I_PUSHQ, I_POPQ
    } icode_e;
    typedef enum logic [3:0] {A_ADD, A_SUB, A_AND, A_XOR, A_MUL} alufun_e;
    typedef enum logic [3:0] {C_YES, C_LE, C_L, C_E, C_NE, C_GE, C_G} cond_e;
    typedef enum logic [3:0] {S_AOK = 4'd1, S_HLT, S_ADR, S_INS} stat_e;
    localparam logic [3:0] RNONE = 4'hF;
endpackage

// File: rtl/execute_stage_if.sv
// execute_stage_if: E-register inputs, forwarding outputs and M-register outputs of the Execute stage.
interface execute_stage_if #(parameter int W = 64);
    logic [3:0]   E_stat, E_icode, E_ifun, E_dstE, E_dstM;
    logic [W-1:0] E_valA, E_valB, E_valC;
    logic         m_exc, W_exc, M_bubble;
    logic [W-1:0] e_valE;
    logic [3:0]   e_dstE;
    logic         e_cnd;
    logic [3:0]   M_stat, M_icode, M_dstE, M_dstM;
    logic         M_cnd;
    logic [W-1:0] M_valE, M_valA;
    modport master (
        output E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_valA, E_valB, E_valC,
        output m_exc, W_exc, M_bubble,
        input  e_valE, e_dstE, e_cnd,
        input  M_stat, M_icode, M_dstE, M_dstM, M_cnd, M_valE, M_valA
    );
    modport slave (
        input  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_valA, E_valB, E_valC,
        input  m_exc, W_exc, M_bubble,
        output e_valE, e_dstE, e_cnd,
        output M_stat, M_icode, M_dstE, M_dstM, M_cnd, M_valE, M_valA
    );
endinterface

// File: rtl/add_64.sv
// add_64: wrap-around adder computing b + a.
module add_64 #(parameter int W = 64) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = b + a;
endmodule

// File: rtl/alu_64.sv
// alu_64: combinational Y86 ALU with ZF/SF/OF; optional MUL when ALU_MUL_EN is defined.
module alu_64 import y86_pkg::*; #(parameter int W = 64) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   fun,
    output logic [W-1:0] val_e,
    output logic         zf,
    output logic         sf,
    output logic         of
);
    logic [W-1:0] and_y, xor_y, add_y, sub_y, mul_y;
    logic         mul_of;
    and_64 #(.W(W)) u_and (.a(a), .b(b), .y(and_y));
    xor_64 #(.W(W)) u_xor (.a(a), .b(b), .y(xor_y));
    add_64 #(.W(W)) u_add (.a(a), .b(b), .y(add_y));
    sub_64 #(.W(W)) u_sub (.a(a), .b(b), .y(sub_y));
`ifdef ALU_MUL_EN
    logic [2*W-1:0] prod;
    // Sign-extended operands make the low 2W bits equal the signed product.
    assign prod   = {{W{b[W-1]}}, b} * {{W{a[W-1]}}, a};
    assign mul_y  = prod[W-1:0];
    assign mul_of = !((&prod[2*W-1:W-1]) || !(|prod[2*W-1:W-1]));
`else
    assign mul_y  = '0;
    assign mul_of = 1'b0;
`endif
    always_comb begin
        val_e = fun == A_ADD ? add_y :
                fun == A_SUB ? sub_y :
                fun == A_AND ? and_y :
                fun == A_XOR ? xor_y :
                fun == A_MUL ? mul_y : '0;
        zf = val_e == '0;
        sf = val_e[W-1];
        of = fun == A_ADD ? (a[W-1] == b[W-1]) && (add_y[W-1] != b[W-1]) :
             fun == A_SUB ? (a[W-1] != b[W-1]) && (sub_y[W-1] != b[W-1]) :
             fun == A_MUL ? mul_of : 1'b0;
    end
endmodule

// File: rtl/and_64.sv
// and_64: bitwise AND unit of the ALU.
module and_64 #(parameter int W = 64) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = b & a;
endmodule

// File: rtl/sub_64.sv
// sub_64: wrap-around subtractor computing b - a.
module sub_64 #(parameter int W = 64) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = b - a;
endmodule

// File: rtl/xor_64.sv
// xor_64: bitwise XOR unit of the ALU.
module xor_64 #(parameter int W = 64) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = b ^ a;
endmodule

// File: rtl/execute_stage.sv
// execute_stage: Y86-64 Execute stage with CC register and E/M pipeline register (ALU_MUL_EN enables MUL).
module execute_stage import y86_pkg::*; #(
    parameter int W          = 64,
    parameter int STACK_STEP = 8
) (
    input  logic           clk,
    input  logic           rst,
    execute_stage_if.slave bus
);
    logic [W-1:0] alu_a, alu_b, alu_val;
    logic [3:0]   alu_fun, e_dst;
    logic         alu_zf, alu_sf, alu_of, set_cc, cnd, lt;
    logic         zf_q, sf_q, of_q, zf_d, sf_d, of_d;
    logic [3:0]   m_stat_q, m_icode_q, m_dste_q, m_dstm_q, m_stat_d, m_icode_d, m_dste_d, m_dstm_d;
    logic         m_cnd_q, m_cnd_d;
    logic [W-1:0] m_vale_q, m_vala_q, m_vale_d, m_vala_d;
    alu_64 #(.W(W)) u_alu (
        .a(alu_a), .b(alu_b), .fun(alu_fun),
        .val_e(alu_val), .zf(alu_zf), .sf(alu_sf), .of(alu_of)
    );
    always_comb begin
        alu_a = bus.E_icode inside {I_RRMOVQ, I_OPQ} ? bus.E_valA :
                bus.E_icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ} ? bus.E_valC :
                bus.E_icode inside {I_CALL, I_PUSHQ} ? -W'(STACK_STEP) :
                bus.E_icode inside {I_RET, I_POPQ} ? W'(STACK_STEP) : '0;
        alu_b = bus.E_icode inside {I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ}
                ? bus.E_valB : '0;
        alu_fun = bus.E_icode == I_OPQ ? bus.E_ifun : A_ADD;
        set_cc = bus.E_icode == I_OPQ && !bus.m_exc && !bus.W_exc && bus.E_stat == S_AOK;
        {zf_d, sf_d, of_d} = set_cc ? {alu_zf, alu_sf, alu_of} : {zf_q, sf_q, of_q};
        // Condition always reflects the CC value before this instruction's update.
        lt = sf_q ^ of_q;
        cnd = bus.E_ifun == C_YES ? 1'b1 :
              bus.E_ifun == C_LE  ? lt | zf_q :
              bus.E_ifun == C_L   ? lt :
              bus.E_ifun == C_E   ? zf_q :
              bus.E_ifun == C_NE  ? !zf_q :
              bus.E_ifun == C_GE  ? !lt :
              bus.E_ifun == C_G   ? !lt && !zf_q : 1'b0;
        e_dst = bus.E_icode == I_RRMOVQ && !cnd ? RNONE : bus.E_dstE;
        m_stat_d  = bus.M_bubble ? S_AOK : bus.E_stat;
        m_icode_d = bus.M_bubble ? I_NOP : bus.E_icode;
        m_cnd_d   = bus.M_bubble ? 1'b0  : cnd;
        m_vale_d  = bus.M_bubble ? '0    : alu_val;
        m_vala_d  = bus.M_bubble ? '0    : bus.E_valA;
        m_dste_d  = bus.M_bubble ? RNONE : e_dst;
        m_dstm_d  = bus.M_bubble ? RNONE : bus.E_dstM;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            {zf_q, sf_q, of_q} <= 3'b100;
            m_stat_q  <= S_AOK;
            m_icode_q <= I_NOP;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= RNONE;
            m_dstm_q  <= RNONE;
        end else begin
            {zf_q, sf_q, of_q} <= {zf_d, sf_d, of_d};
            m_stat_q  <= m_stat_d;
            m_icode_q <= m_icode_d;
            m_cnd_q   <= m_cnd_d;
            m_vale_q  <= m_vale_d;
            m_vala_q  <= m_vala_d;
            m_dste_q  <= m_dste_d;
            m_dstm_q  <= m_dstm_d;
        end
    end
    assign bus.e_valE  = alu_val;
    assign bus.e_dstE  = e_dst;
    assign bus.e_cnd   = cnd;
    assign bus.M_stat  = m_stat_q;
    assign bus.M_icode = m_icode_q;
    assign bus.M_cnd   = m_cnd_q;
    assign bus.M_valE  = m_vale_q;
    assign bus.M_valA  = m_vala_q;
    assign bus.M_dstE  = m_dste_q;
    assign bus.M_dstM  = m_dstm_q;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed plus randomized checks of execute_stage against an arithmetic reference model.
module tb_execute_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int failed = 0;
    logic mzf, msf, mof;
    localparam logic [159:0] BUBBLE = {4'd1, 4'd1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF};
    always #5 clk = ~clk;
    execute_stage_if #(.W(64)) bus ();
    execute_stage #(.W(64), .STACK_STEP(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] mreg();
        return {bus.M_stat, bus.M_icode, bus.M_cnd, bus.M_valE, bus.M_valA, bus.M_dstE, bus.M_dstM};
    endfunction

    function automatic void model_alu(input logic [3:0] ic, input logic [3:0] fn,
                                      input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                                      output logic [63:0] val, output logic z, output logic s, output logic o);
        logic [63:0] a, b;
        logic [3:0] f;
        logic signed [127:0] sa, sb, full;
        case (ic)
            4'd2, 4'd6:       a = va;
            4'd3, 4'd4, 4'd5: a = vc;
            4'd8, 4'd10:      a = 64'hFFFF_FFFF_FFFF_FFF8;
            4'd9, 4'd11:      a = 64'd8;
            default:          a = 64'd0;
        endcase
        b = (ic inside {4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11}) ? vb : 64'd0;
        f = (ic == 4'd6) ? fn : 4'd0;
        sa = $signed(a);
        sb = $signed(b);
        case (f)
            4'd0: full = sb + sa;
            4'd1: full = sb - sa;
            4'd2: full = sb & sa;
            4'd3: full = sb ^ sa;
`ifdef ALU_MUL_EN
            4'd4: full = sb * sa;
`endif
            default: full = '0;
        endcase
        val = full[63:0];
        o = full != {{64{val[63]}}, val};
        z = val == 64'd0;
        s = val[63];
    endfunction

    function automatic logic model_cnd(input logic [3:0] fn);
        case (fn)
            4'd0: return 1'b1;
            4'd1: return (msf != mof) || mzf;
            4'd2: return msf != mof;
            4'd3: return mzf;
            4'd4: return !mzf;
            4'd5: return msf == mof;
            4'd6: return (msf == mof) && !mzf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input logic [3:0] st, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic me, input logic we, input logic bb);
        logic [63:0] val;
        logic z, s, o, c;
        logic [3:0] d;
        bus.E_stat = st; bus.E_icode = ic; bus.E_ifun = fn;
        bus.E_valA = va; bus.E_valB = vb; bus.E_valC = vc;
        bus.E_dstE = de; bus.E_dstM = dm;
        bus.m_exc = me; bus.W_exc = we; bus.M_bubble = bb;
        #1;
        model_alu(ic, fn, va, vb, vc, val, z, s, o);
        c = model_cnd(fn);
        d = (ic == 4'd2 && !c) ? 4'hF : de;
        chk("e_valE", 160'(bus.e_valE), 160'(val));
        chk("e_dstE", 160'(bus.e_dstE), 160'(d));
        chk("e_cnd", 160'(bus.e_cnd), 160'(c));
        @(posedge clk);
        #1;
        chk("M_reg", mreg(), bb ? BUBBLE : 160'({st, ic, c, val, va, d, dm}));
        if (ic == 4'd6 && !me && !we && st == 4'd1) {mzf, msf, mof} = {z, s, o};
    endtask

    task automatic probe_cc();
        bus.E_icode = 4'd7; bus.M_bubble = 1'b0;
        for (int f = 0; f < 8; f++) begin
            bus.E_ifun = 4'(f);
            #1;
            chk($sformatf("cnd_probe%0d", f), 160'(bus.e_cnd), 160'(model_cnd(4'(f))));
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return '1;
            4: return 64'($urandom_range(0, 16));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        {bus.E_stat, bus.E_icode, bus.E_ifun, bus.E_dstE, bus.E_dstM} = '0;
        {bus.E_valA, bus.E_valB, bus.E_valC} = '0;
        {bus.m_exc, bus.W_exc, bus.M_bubble} = '0;
        {mzf, msf, mof} = 3'b100;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_M", mreg(), BUBBLE);
        probe_cc();
        step(1, 6, 1, 64'd5, 64'd5, 0, 4'd2, 4'hF, 0, 0, 0);
        chk("sub_MvalE", 160'(bus.M_valE), 160'd0);
        probe_cc();
        step(1, 6, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0, 4'd3, 4'hF, 0, 0, 0);
        chk("add_MvalE", 160'(bus.M_valE), 160'(64'hFFFF_FFFF_FFFF_FFFE));
        probe_cc();
        step(1, 10, 0, 64'd7, 64'h100, 0, 4'd4, 4'hF, 0, 0, 0);
        chk("push_MvalE", 160'(bus.M_valE), 160'(64'hF8));
        chk("push_Micode", 160'(bus.M_icode), 160'(4'hA));
        probe_cc();
        step(1, 6, 0, 64'd1, 64'd1, 0, 4'd5, 4'hF, 0, 0, 0);
        step(1, 2, 1, 64'd9, 64'd0, 0, 4'd3, 4'hF, 0, 0, 0);
        chk("cmovle_dstE", 160'(bus.M_dstE), 160'(4'hF));
        chk("cmovle_cnd", 160'(bus.M_cnd), 160'(1'b0));
        step(1, 6, 3, 64'hF0F0, 64'hFFFF, 0, 4'd6, 4'hF, 1, 0, 0);
        chk("xor_mexc_MvalE", 160'(bus.M_valE), 160'(64'h0F0F));
        probe_cc();
        step(1, 6, 3, 64'hF0F0, 64'hFFFF, 0, 4'd6, 4'hF, 0, 0, 1);
        chk("bubble_Micode", 160'(bus.M_icode), 160'(4'd1));
        probe_cc();
        for (int i = 0; i < 300; i++) begin
            logic [3:0] ic;
            ic = 4'($urandom_range(0, 11));
            step(($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 4)) : 4'd1, ic,
                 (ic == 4'd6) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 7)),
                 rnd64(), rnd64(), rnd64(), 4'($urandom), 4'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            if (i % 20 == 19) probe_cc();
        end
        step(1, 6, 1, 64'd2, 64'd1, 0, 4'd1, 4'hF, 0, 0, 0);
        rst = 1'b1;
        bus.E_icode = 4'd6; bus.E_ifun = 4'd0; bus.E_valA = 64'd3; bus.E_valB = 64'd4;
        @(posedge clk);
        #1;
        chk("rst_mid_M", mreg(), BUBBLE);
        rst = 1'b0;
        {mzf, msf, mof} = 3'b100;
        probe_cc();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
